// File: rtl/ones_count_pkg.sv
// rtl/ones_count_pkg.sv - shared types and sizing for the counting-ones control unit
package ones_count_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Tally width large enough to hold every value from 0 to width inclusive
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/ones_tally_counter.sv
// rtl/ones_tally_counter.sv - clearable up-counter used for the ones tally and the step count
module ones_tally_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Clear wins over increment; the count range never reaches wrap-around
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ones_count_ctrl.sv
// rtl/ones_count_ctrl.sv - sequencer and ones tally for the shift-right operand register
module ones_count_ctrl
    import ones_count_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             z,
    input  logic             count_enable,
    output logic             load,
    output logic             sr,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] ones_count
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] step;
    logic             at_limit;
    logic             shift_active;
    logic             stuck;
    logic             in_load;

    // A run that has already shifted WIDTH times yet still sees a non-zero
    // operand indicates a broken datapath; stop shifting and flag it.
    assign in_load      = (state == ST_LOAD);
    assign at_limit     = (step == CNT_W'(WIDTH));
    assign shift_active = (state == ST_SHIFT) && !z && !at_limit;
    assign stuck        = (state == ST_SHIFT) && !z && at_limit;

    ones_tally_counter #(.CNT_W(CNT_W)) u_tally (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (in_load),
        .inc   (shift_active && count_enable),
        .count (ones_count)
    );

    ones_tally_counter #(.CNT_W(CNT_W)) u_step (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (in_load),
        .inc   (shift_active),
        .count (step)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fault flag: cleared when a new run loads, held through DONE and IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (in_load) begin
            err <= 1'b0;
        end else if (stuck) begin
            err <= 1'b1;
        end
    end

    // Next-state decode; start is only looked at in IDLE
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_SHIFT;
            ST_SHIFT: if (z || at_limit) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output decode; sr is qualified by z so no shift is issued once the operand is empty
    always_comb begin
        load = 1'b0;
        sr   = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_LOAD: begin
                load = 1'b1;
                busy = 1'b1;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                sr   = shift_active;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ones_count_ctrl.sv
// tb/tb_ones_count_ctrl.sv - randomized self-checking bench with an operand register model
module tb_ones_count_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       z;
    logic       count_enable;
    logic       load;
    logic       sr;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] ones_count;

    logic [7:0] operand = 8'h00;
    logic [7:0] op_reg = 8'h00;
    bit         stuck = 1'b0;

    int pass_cnt = 0;
    int total = 0;

    always #5 clk = ~clk;

    ones_count_ctrl #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .z            (z),
        .count_enable (count_enable),
        .load         (load),
        .sr           (sr),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .ones_count   (ones_count)
    );

    always @(posedge clk) begin
        if (load) op_reg <= operand;
        else if (sr) op_reg <= op_reg >> 1;
    end

    assign z            = stuck ? 1'b0 : (op_reg == 8'h00);
    assign count_enable = stuck ? 1'b1 : op_reg[0];

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        total++; if ({load, sr, busy, done, err} !== 5'b0) $display("FAIL reset_flags got=%b want=00000", {load, sr, busy, done, err}); else pass_cnt++;
        total++; if (ones_count !== 4'd0) $display("FAIL reset_count got=%0d want=0", ones_count); else pass_cnt++;
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL idle_no_start busy got=%b want=0", busy); else pass_cnt++;
    endtask

    // Reference: k = highest set bit index + 1, count = popcount, DONE at k+3
    task automatic run_count(input logic [7:0] op, input bit stk, input string nm);
        int cyc, load_n, load_c, sr_n, sr_first, sr_last, done_c, cnt, e;
        int k, exp_cnt, exp_sr, exp_first, exp_last, exp_done;
        k = 0;
        exp_cnt = 0;
        for (int i = 0; i < 8; i++) if (op[i]) begin k = i + 1; exp_cnt++; end
        exp_sr    = stk ? 8 : k;
        if (stk) exp_cnt = 8;
        exp_done  = exp_sr + 3;
        exp_first = (exp_sr > 0) ? 2 : -1;
        exp_last  = (exp_sr > 0) ? exp_sr + 1 : -1;

        operand = op;
        stuck = stk;
        @(negedge clk);
        start = 1'b1;
        cyc = 0; load_n = 0; load_c = -1; sr_n = 0; sr_first = -1; sr_last = -1; done_c = -1; cnt = -1; e = -1;
        while (done_c < 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (load) begin load_n++; if (load_c < 0) load_c = cyc; end
            if (sr) begin sr_n++; if (sr_first < 0) sr_first = cyc; sr_last = cyc; end
            if (done) begin done_c = cyc; cnt = int'(ones_count); e = int'(err); end
        end
        total++; if (load_n !== 1 || load_c !== 1) $display("FAIL %s load got=%0d@%0d want=1@1", nm, load_n, load_c); else pass_cnt++;
        total++; if (sr_n !== exp_sr || sr_first !== exp_first || sr_last !== exp_last)
            $display("FAIL %s sr got=%0d[%0d..%0d] want=%0d[%0d..%0d]", nm, sr_n, sr_first, sr_last, exp_sr, exp_first, exp_last); else pass_cnt++;
        total++; if (done_c !== exp_done) $display("FAIL %s done_cycle got=%0d want=%0d", nm, done_c, exp_done); else pass_cnt++;
        total++; if (cnt !== exp_cnt) $display("FAIL %s ones_count got=%0d want=%0d", nm, cnt, exp_cnt); else pass_cnt++;
        total++; if (e !== int'(stk)) $display("FAIL %s err got=%0d want=%0d", nm, e, int'(stk)); else pass_cnt++;
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0 || int'(ones_count) !== exp_cnt || err !== stk)
            $display("FAIL %s hold got=done%b busy%b cnt%0d err%b want=done0 busy0 cnt%0d err%0d", nm, done, busy, ones_count, err, exp_cnt, int'(stk));
        else pass_cnt++;
        stuck = 1'b0;
    endtask

    task automatic test_patterns();
        run_count(8'b10110110, 1'b0, "op_b6");
        run_count(8'h00, 1'b0, "op_00");
        run_count(8'hFF, 1'b0, "op_ff");
        run_count(8'h80, 1'b0, "op_80");
    endtask

    task automatic test_stuck();
        run_count(8'h00, 1'b1, "stuck");
        run_count(8'h03, 1'b0, "after_stuck");
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) run_count(8'($urandom_range(0, 255)), 1'b0, "random");
    endtask

    // start held high: second run is accepted in the IDLE cycle right after DONE
    task automatic test_back_to_back();
        int cyc, k1, k2, done1, load2, done2, clr_c;
        int d_seen[$];
        int c_seen[$];
        int l_seen[$];
        int cnt_at_clr;
        k1 = 1; k2 = 2;
        done1 = k1 + 3;
        load2 = done1 + 2;
        done2 = (done1 + 1) + k2 + 3;
        clr_c = load2 + 1;
        cnt_at_clr = -1;
        operand = 8'h01;
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        while (cyc < done2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (load) l_seen.push_back(cyc);
            if (done) begin d_seen.push_back(cyc); c_seen.push_back(int'(ones_count)); operand = 8'h02; end
            if (cyc == clr_c) cnt_at_clr = int'(ones_count);
        end
        start = 1'b0;
        total++; if (d_seen.size() !== 2 || d_seen[0] !== done1 || d_seen[1] !== done2)
            $display("FAIL b2b_done got=n%0d first=%0d want=%0d,%0d", d_seen.size(), (d_seen.size() > 0) ? d_seen[0] : -1, done1, done2); else pass_cnt++;
        total++; if (l_seen.size() !== 2 || l_seen[0] !== 1 || l_seen[1] !== load2)
            $display("FAIL b2b_load got=n%0d want=1,%0d", l_seen.size(), load2); else pass_cnt++;
        total++; if (c_seen.size() !== 2 || c_seen[0] !== 1 || c_seen[1] !== 1)
            $display("FAIL b2b_count got=n%0d want=1,1", c_seen.size()); else pass_cnt++;
        total++; if (cnt_at_clr !== 0) $display("FAIL b2b_clear got=%0d want=0", cnt_at_clr); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        operand = 8'b10110110;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (busy !== 1'b1 || ones_count === 4'd0) $display("FAIL mid_partial got=busy%b cnt%0d want=busy1 cnt>0", busy, ones_count); else pass_cnt++;
        rst_n = 1'b0;
        @(negedge clk);
        total++; if ({load, sr, busy, done, err} !== 5'b0 || ones_count !== 4'd0)
            $display("FAIL mid_reset got=%b cnt%0d want=00000 cnt0", {load, sr, busy, done, err}, ones_count); else pass_cnt++;
        rst_n = 1'b1;
        run_count(8'b10110110, 1'b0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_stuck();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
